// File: rtl/chain_mixer_sequencer_if.sv
// Host and actuator signal bundle for the serial mixer chain sequencer.
// The host side (start/abort/mask, status back) is the master; the sequencer is the slave.
interface chain_mixer_sequencer_if #(
  parameter int NUM_STAGES = 32
);
  localparam int IDX_W = $clog2(NUM_STAGES);

  logic                  start;
  logic                  abort;
  logic [NUM_STAGES-1:0] stage_mask;
  logic                  in_valve;
  logic [NUM_STAGES-1:0] reagent_valve;
  logic [NUM_STAGES-1:0] mix_pump;
  logic [NUM_STAGES-1:0] xfer_valve;
  logic [IDX_W-1:0]      stage_idx;
  logic                  busy;
  logic                  done;
  logic                  aborted;

  modport master (
    output start, abort, stage_mask,
    input  in_valve, reagent_valve, mix_pump, xfer_valve, stage_idx, busy, done, aborted
  );

  modport slave (
    input  start, abort, stage_mask,
    output in_valve, reagent_valve, mix_pump, xfer_valve, stage_idx, busy, done, aborted
  );
endinterface

// File: rtl/chain_mixer_sequencer.sv
// Sequencer for the serial mixer chain: fill j0, then per stage load reagent, mix, transfer.
// All actuator and status outputs are registered from the next-state decode.
//
// state  | meaning
// IDLE   | waiting for start, all actuators closed
// FILL   | j0 inlet valve open
// LOAD   | reagent valve k_i open (enabled stage only)
// MIX    | mixer pump i running (enabled stage only)
// XFER   | transfer valve i open, passing j_{i+1} onward
// DONE   | one-cycle completion pulse
module chain_mixer_sequencer #(
  parameter int NUM_STAGES  = 32,
  parameter int FILL_CYCLES = 4,
  parameter int LOAD_CYCLES = 8,
  parameter int MIX_CYCLES  = 16,
  parameter int XFER_CYCLES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  chain_mixer_sequencer_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_STAGES);
  localparam int MAX_A = (FILL_CYCLES > LOAD_CYCLES) ? FILL_CYCLES : LOAD_CYCLES;
  localparam int MAX_B = (MIX_CYCLES > XFER_CYCLES) ? MIX_CYCLES : XFER_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_LOAD, S_MIX, S_XFER, S_DONE} state_t;

  state_t                state, state_nx;
  logic [CNT_W-1:0]      cnt, cnt_nx;
  logic [IDX_W-1:0]      idx, idx_nx, idx_p1;
  logic [NUM_STAGES-1:0] mask_q, mask_nx;
  logic                  cnt_tc;

  logic                  in_valve_q, in_valve_nx;
  logic [NUM_STAGES-1:0] rv_q, rv_nx;
  logic [NUM_STAGES-1:0] mp_q, mp_nx;
  logic [NUM_STAGES-1:0] xv_q, xv_nx;
  logic                  busy_q, busy_nx;
  logic                  done_q, done_nx;
  logic                  aborted_q, aborted_nx;

  assign idx_p1 = idx + IDX_W'(1);
  assign cnt_tc = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      mask_q     <= '0;
      in_valve_q <= 1'b0;
      rv_q       <= '0;
      mp_q       <= '0;
      xv_q       <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      idx        <= idx_nx;
      mask_q     <= mask_nx;
      in_valve_q <= in_valve_nx;
      rv_q       <= rv_nx;
      mp_q       <= mp_nx;
      xv_q       <= xv_nx;
      busy_q     <= busy_nx;
      done_q     <= done_nx;
      aborted_q  <= aborted_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt_tc ? cnt : cnt - CNT_W'(1);
    idx_nx     = idx;
    mask_nx    = mask_q;
    aborted_nx = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_nx = S_FILL;
          mask_nx  = bus.stage_mask;
          idx_nx   = '0;
          cnt_nx   = CNT_W'(FILL_CYCLES - 1);
        end
      end
      S_FILL: begin
        if (cnt_tc) begin
          if (mask_q[0]) begin
            state_nx = S_LOAD;
            cnt_nx   = CNT_W'(LOAD_CYCLES - 1);
          end else begin
            state_nx = S_XFER;
            cnt_nx   = CNT_W'(XFER_CYCLES - 1);
          end
        end
      end
      S_LOAD: begin
        if (cnt_tc) begin
          state_nx = S_MIX;
          cnt_nx   = CNT_W'(MIX_CYCLES - 1);
        end
      end
      S_MIX: begin
        if (cnt_tc) begin
          state_nx = S_XFER;
          cnt_nx   = CNT_W'(XFER_CYCLES - 1);
        end
      end
      S_XFER: begin
        if (cnt_tc) begin
          if (idx == LAST_IDX) begin
            state_nx = S_DONE;
            cnt_nx   = '0;
          end else begin
            idx_nx = idx_p1;
            if (mask_q[idx_p1]) begin
              state_nx = S_LOAD;
              cnt_nx   = CNT_W'(LOAD_CYCLES - 1);
            end else begin
              state_nx = S_XFER;
              cnt_nx   = CNT_W'(XFER_CYCLES - 1);
            end
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        idx_nx   = '0;
      end
      default: state_nx = S_IDLE;
    endcase
    // The DONE cycle counts as a completed run, so abort there raises no pulse.
    if (bus.abort && state != S_IDLE) begin
      state_nx   = S_IDLE;
      cnt_nx     = '0;
      idx_nx     = '0;
      aborted_nx = (state != S_DONE);
    end
  end

  always_comb begin
    in_valve_nx     = (state_nx == S_FILL);
    rv_nx           = '0;
    mp_nx           = '0;
    xv_nx           = '0;
    rv_nx[idx_nx]   = (state_nx == S_LOAD);
    mp_nx[idx_nx]   = (state_nx == S_MIX);
    xv_nx[idx_nx]   = (state_nx == S_XFER);
    busy_nx         = (state_nx != S_IDLE);
    done_nx         = (state_nx == S_DONE);
  end

  assign bus.in_valve      = in_valve_q;
  assign bus.reagent_valve = rv_q;
  assign bus.mix_pump      = mp_q;
  assign bus.xfer_valve    = xv_q;
  assign bus.stage_idx     = idx;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
  assign bus.aborted       = aborted_q;
endmodule

// File: doc/chain_mixer_sequencer.md
# chain_mixer_sequencer

Sequencing controller for the serial mixer chain. Each stage i mixes the running stream j_i with reagent k_i to produce j_{i+1}. The block drives the chain's valve and pump control lines. It fills the stream inlet, then walks stages 0..NUM_STAGES-1. For each enabled stage it injects the reagent, runs the mixer, then transfers the product to the next stage, each for a fixed cycle budget. It sits between the assay host (start/abort/mask) and the chain's actuator drivers.

## Interface
- NUM_STAGES, 32, number of mixer stages in the chain (2..64)
- FILL_CYCLES, 4, cycles the j0 inlet valve stays open (>=1)
- LOAD_CYCLES, 8, cycles reagent valve k_i stays open per stage (>=1)
- MIX_CYCLES, 16, cycles mixer pump i runs per stage (>=1)
- XFER_CYCLES, 4, cycles transfer valve i (j_{i+1} path) stays open (>=1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  terminate the run; effective in every state
- stage_mask  in  NUM_STAGES  1 = add reagent at stage i; 0 = bypass (transfer only); latched at start
- in_valve  out  1  opens the j0 inlet
- reagent_valve  out  NUM_STAGES  one-hot-or-zero; bit i opens k_i
- mix_pump  out  NUM_STAGES  one-hot-or-zero; bit i runs mixer i
- xfer_valve  out  NUM_STAGES  one-hot-or-zero; bit i passes j_{i+1} onward
- stage_idx  out  clog2(NUM_STAGES)  stage currently being processed
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse when abort terminates a run

## Operation
- States: IDLE, FILL, LOAD, MIX, XFER, DONE.
- IDLE: start=1 and abort=0 → FILL. Latch stage_mask. Clear stage_idx. Load the duration counter.
- FILL → after FILL_CYCLES → LOAD if mask[0], else XFER.
- LOAD → after LOAD_CYCLES → MIX.
- MIX → after MIX_CYCLES → XFER.
- XFER → after XFER_CYCLES:
  - if stage_idx = NUM_STAGES-1 → DONE;
  - else stage_idx+1 → LOAD if mask[idx+1], else XFER.
- DONE: one cycle with done=1, then → IDLE.
- A bypassed stage (mask bit 0) never asserts its reagent_valve or mix_pump bit.
- Duration counter: one down-counter sized for the largest budget. Loaded with budget-1 on state entry. Transition when it reaches 0. Each state therefore lasts exactly its budget.
- Output decode, all registered:
  - in_valve = FILL;
  - reagent_valve[stage_idx] = LOAD;
  - mix_pump[stage_idx] = MIX;
  - xfer_valve[stage_idx] = XFER.
- At most one actuator bit is high in any cycle across all four outputs.
- stage_mask changes during a run are ignored.
- start while busy is ignored.
- abort=1 in any non-IDLE state → IDLE next cycle. All actuators drop that same edge. aborted pulses one cycle. done is not asserted.
- abort in IDLE is a no-op. abort and start together in IDLE: stay IDLE, no pulse.
- abort in the DONE cycle: done still pulses (run complete), aborted stays low.
- Reset: all outputs 0, state IDLE, stage_idx 0, counter 0, latched mask 0.
- Reset mid-run: actuators close immediately (asynchronous). No done or aborted pulse.

## Timing
- Reference point: start is sampled at edge 0.
- in_valve is high for cycles 1..FILL_CYCLES.
- Stage actuators follow back-to-back. No gap cycles between states.
- Enabled stage: LOAD_CYCLES + MIX_CYCLES + XFER_CYCLES cycles. Bypassed stage: XFER_CYCLES cycles.
- done is high in cycle 1 + FILL_CYCLES + Σ(stage durations). busy falls the following cycle.
- A new start is accepted the cycle after done (first IDLE cycle).
- abort sampled at edge t: actuators and busy are 0 from cycle t+1, and aborted=1 in cycle t+1.

## Test plan
- NUM_STAGES=4, F=2, L=3, M=5, X=2, mask=4'b1111, pulse start: in_valve high cycles 1–2; stage 0 reagent cycles 3–5, pump 6–10, xfer 11–12; pattern repeats per stage; done=1 at cycle 43; one-hot invariant holds every cycle.
- Same config, mask=4'b0101: stages 1 and 3 show only xfer (2 cycles); reagent_valve[1], [3] and mix_pump[1], [3] never high; done at cycle 1+2+10+2+10+2=27.
- Abort at cycle 8 (stage 0 MIX) → all actuators 0 and aborted=1 at cycle 9, busy=0, done never asserted; a new start at cycle 12 begins FILL at cycle 13.
- start pulses during a run, and mask changes mid-run → no effect on sequence or done cycle; start and abort together in IDLE → stays IDLE, no pulses.
- rst_n asserted during stage 2 XFER → every output 0 asynchronously, before the next edge; after release, IDLE with stage_idx=0 and no done or aborted pulse.
- Default parameters (32 stages), mask all ones → done at cycle 1+4+32·28=901; stage_idx steps 0..31 and never exceeds 31.
